sram_1rw1r_wmask: RTL

- Parametrised, synthesizable dual-port SRAM macro model for the generated memory set.
- Port 0 is read/write with a per-byte write mask. Port 1 is read-only.
- Each read port has a configurable 1- or 2-stage output pipeline and a valid strobe.
- A hardware init engine zeroes the whole array after reset. Read-during-write collisions between ports are resolved deterministically and flagged.

---
 rtl/sram_pkg.sv | 19 +
 rtl/sram_read_pipe.sv | 58 +++++
 rtl/sram_1rw1r_wmask.sv | 127 ++++++++++++
 3 files changed

// File: rtl/sram_pkg.sv
// Shared types and constants for the 1RW+1R write-masked SRAM model.
package sram_pkg;

  // Init engine states: sweeping zeros through the array, then normal service.
  typedef enum logic {
    INIT  = 1'b0,
    READY = 1'b1
  } state_t;

  // The only read pipeline depths the macro model supports.
  localparam int READ_LATENCY_1 = 1;
  localparam int READ_LATENCY_2 = 2;

  // Width of one write-mask lane.
  function automatic int calc_wmask_size(input int data_width, input int num_wmasks);
    return data_width / num_wmasks;
  endfunction

endpackage

// File: rtl/sram_read_pipe.sv
// Read output pipeline: data, valid strobe and collision flag delayed by
// READ_LATENCY edges. Data only advances with a valid read, so each output
// holds the last read value while idle.
module sram_read_pipe
  import sram_pkg::*;
#(
  parameter int DATA_WIDTH   = 32,
  parameter int READ_LATENCY = READ_LATENCY_1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_coll,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_valid,
  output logic                  out_coll
);

  if (READ_LATENCY == READ_LATENCY_1) begin : g_lat1
    // Single output stage capturing the array read at the sampling edge.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        out_data  <= '0;
        out_valid <= 1'b0;
        out_coll  <= 1'b0;
      end else begin
        out_valid <= in_valid;
        out_coll  <= in_valid & in_coll;
        if (in_valid) out_data <= in_data;
      end
    end
  end else begin : g_lat2
    logic [DATA_WIDTH-1:0] s1_data;
    logic                  s1_valid;
    logic                  s1_coll;

    // First stage captures the array read; second stage presents it one edge later.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        s1_data   <= '0;
        s1_valid  <= 1'b0;
        s1_coll   <= 1'b0;
        out_data  <= '0;
        out_valid <= 1'b0;
        out_coll  <= 1'b0;
      end else begin
        s1_valid  <= in_valid;
        s1_coll   <= in_valid & in_coll;
        if (in_valid) s1_data <= in_data;
        out_valid <= s1_valid;
        out_coll  <= s1_valid & s1_coll;
        if (s1_valid) out_data <= s1_data;
      end
    end
  end

endmodule

// File: rtl/sram_1rw1r_wmask.sv
// Dual-port SRAM model: port 0 read/write with per-lane write mask, port 1
// read-only. An init engine zeroes the array after every reset; port 1 reads
// colliding with a port 0 write return the old word and are flagged.
//
// Handshake: a port accepts a request on any rising edge where its csb is low
// and init_busy is low; there is no backpressure. Each accepted read produces
// exactly one cycle of doutN_valid READ_LATENCY edges later (counting the
// sampling edge as the first); doutN only changes alongside its valid.
module sram_1rw1r_wmask
  import sram_pkg::*;
#(
  parameter int DATA_WIDTH   = 32,
  parameter int ADDR_WIDTH   = 8,
  parameter int NUM_WMASKS   = 4,
  parameter int READ_LATENCY = 1
) (
  input  logic                  clk0,
  input  logic                  rst0,
  output logic                  init_busy,
  input  logic                  csb0,
  input  logic                  web0,
  input  logic [NUM_WMASKS-1:0] wmask0,
  input  logic [ADDR_WIDTH-1:0] addr0,
  input  logic [DATA_WIDTH-1:0] din0,
  output logic [DATA_WIDTH-1:0] dout0,
  output logic                  dout0_valid,
  input  logic                  csb1,
  input  logic [ADDR_WIDTH-1:0] addr1,
  output logic [DATA_WIDTH-1:0] dout1,
  output logic                  dout1_valid,
  output logic                  collision1
);

  localparam int WMASK_SIZE = calc_wmask_size(DATA_WIDTH, NUM_WMASKS);
  localparam int RAM_DEPTH  = 1 << ADDR_WIDTH;

  if (READ_LATENCY != READ_LATENCY_1 && READ_LATENCY != READ_LATENCY_2) begin : g_bad_latency
    $error("sram_1rw1r_wmask: READ_LATENCY must be 1 or 2");
  end
  if (DATA_WIDTH % NUM_WMASKS != 0) begin : g_bad_mask
    $error("sram_1rw1r_wmask: DATA_WIDTH must be a multiple of NUM_WMASKS");
  end

  logic [DATA_WIDTH-1:0] mem [RAM_DEPTH];
  state_t                state;
  state_t                state_nxt;
  logic [ADDR_WIDTH-1:0] init_addr;
  logic                  ready;
  logic                  wr_en;
  logic                  rd0_en;
  logic                  rd1_en;
  logic                  coll;
  logic                  coll0_unused;

  assign ready     = (state == READY);
  assign init_busy = (state == INIT);
  assign wr_en     = ready & ~csb0 & ~web0;
  assign rd0_en    = ready & ~csb0 & web0;
  assign rd1_en    = ready & ~csb1;
  // Only a write that actually changes a lane counts as a collision.
  assign coll      = wr_en & (|wmask0) & rd1_en & (addr0 == addr1);

  // State register and init sweep address; reset restarts the sweep from 0.
  always_ff @(posedge clk0 or posedge rst0) begin
    if (rst0) begin
      state     <= INIT;
      init_addr <= '0;
    end else begin
      state <= state_nxt;
      if (state == INIT) init_addr <= init_addr + ADDR_WIDTH'(1);
    end
  end

  // Leave INIT on the edge that clears the last address.
  always_comb begin
    state_nxt = state;
    case (state)
      INIT:    if (init_addr == {ADDR_WIDTH{1'b1}}) state_nxt = READY;
      READY:   state_nxt = READY;
      default: state_nxt = INIT;
    endcase
  end

  // Array update: zero sweep during INIT, lane-masked port 0 writes when READY.
  // Reset is not in the sensitivity list so the contents survive it untouched.
  always_ff @(posedge clk0) begin
    if (!rst0) begin
      if (state == INIT) begin
        mem[init_addr] <= '0;
      end else if (wr_en) begin
        for (int i = 0; i < NUM_WMASKS; i++) begin
          if (wmask0[i]) mem[addr0][i*WMASK_SIZE +: WMASK_SIZE] <= din0[i*WMASK_SIZE +: WMASK_SIZE];
        end
      end
    end
  end

  // Pipelines sample the array before this edge's write lands: read-before-write.
  sram_read_pipe #(
    .DATA_WIDTH   (DATA_WIDTH),
    .READ_LATENCY (READ_LATENCY)
  ) u_pipe0 (
    .clk       (clk0),
    .rst       (rst0),
    .in_valid  (rd0_en),
    .in_data   (mem[addr0]),
    .in_coll   (1'b0),
    .out_data  (dout0),
    .out_valid (dout0_valid),
    .out_coll  (coll0_unused)
  );

  sram_read_pipe #(
    .DATA_WIDTH   (DATA_WIDTH),
    .READ_LATENCY (READ_LATENCY)
  ) u_pipe1 (
    .clk       (clk0),
    .rst       (rst0),
    .in_valid  (rd1_en),
    .in_data   (mem[addr1]),
    .in_coll   (coll),
    .out_data  (dout1),
    .out_valid (dout1_valid),
    .out_coll  (collision1)
  );

endmodule
